// File: rtl/ip_reg_pkg.sv
// ============================================================================
// Module      : ip_reg_pkg
// Description : Shared FSM state encoding and default sizing for ip_reg_router.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ip_reg_pkg;

    localparam int c_DEF_NPORTS = 8;
    localparam int c_DEF_AW     = 32;
    localparam int c_DEF_DW     = 32;
    localparam int c_DEF_TIMEOUT = 256;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/ip_reg_port_match.sv
// ============================================================================
// Module      : ip_reg_port_match
// Description : Masked address compare for one downstream port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ip_reg_port_match #(
    parameter int AW = 32
) (
    input  logic [AW-1:0] addr_i,
    input  logic [AW-1:0] mask_i,
    input  logic [AW-1:0] value_i,
    output logic          hit_o
);

    logic w_disabled;

    // An all-ones mask parks the port rather than demanding an exact match.
    assign w_disabled = &mask_i;
    assign hit_o      = !w_disabled && ((addr_i & mask_i) == (value_i & mask_i));

endmodule

`default_nettype wire

// File: rtl/ip_reg_router.sv
// ============================================================================
// Module      : ip_reg_router
// Description : Routes single upstream register requests to NPORTS downstream
//               ports by masked address decode (reads: lowest hit, writes:
//               broadcast). Define IP_REG_ROUTER_TIMEOUT_EN for ack timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ip_reg_router
    import ip_reg_pkg::*;
#(
    parameter int NPORTS  = c_DEF_NPORTS,
    parameter int AW      = c_DEF_AW,
    parameter int DW      = c_DEF_DW,
    parameter int TIMEOUT = c_DEF_TIMEOUT
) (
    input  logic                 clockCore,
    input  logic                 resetCore,
    input  logic                 registerSelect,
    input  logic                 registerRead,
    input  logic [AW-1:0]        registerAddress,
    input  logic [DW-1:0]        registerWriteData,
    output logic                 registerAck,
    output logic                 registerError,
    output logic [DW-1:0]        registerReadData,
    output logic                 registerBusy,
    input  logic [NPORTS*AW-1:0] portMask,
    input  logic [NPORTS*AW-1:0] portValue,
    output logic [NPORTS-1:0]    portSelect,
    output logic [NPORTS-1:0]    portRead,
    output logic [AW-1:0]        portAddress,
    output logic [DW-1:0]        portWriteData,
    input  logic [NPORTS-1:0]    portAck,
    input  logic [NPORTS-1:0]    portError,
    input  logic [NPORTS*DW-1:0] portReadData
);

    if (NPORTS < 1 || NPORTS > 16) begin : g_nports_range
        $error("ip_reg_router: NPORTS must be 1..16");
    end
    if (TIMEOUT < 2) begin : g_timeout_range
        $error("ip_reg_router: TIMEOUT must be at least 2");
    end

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic              read_q, read_d;
    logic [NPORTS-1:0] target_q, target_d;
    logic [NPORTS-1:0] acked_q, acked_d;
    logic              err_q, err_d;
    logic [DW-1:0]     rdata_q, rdata_d;

    logic [NPORTS-1:0] w_hit;
    logic [NPORTS-1:0] w_lowest;
    logic [NPORTS-1:0] w_ack_tgt;
    logic              w_all_acked;
    logic              w_err_in;
    logic              w_timeout;
    logic [DW-1:0]     w_ack_data;

    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        ip_reg_port_match #(
            .AW (AW)
        ) u_match (
            .addr_i  (addr_q),
            .mask_i  (portMask[i*AW +: AW]),
            .value_i (portValue[i*AW +: AW]),
            .hit_o   (w_hit[i])
        );
    end

    always_comb begin
        w_lowest = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_lowest    = '0;
                w_lowest[i] = 1'b1;
            end
        end
    end

    // Only acks from ports we actually selected are allowed to make progress.
    assign w_ack_tgt   = portAck & target_q;
    assign w_all_acked = ((acked_q | w_ack_tgt) == target_q);
    assign w_err_in    = |(w_ack_tgt & portError);

    always_comb begin
        w_ack_data = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (w_ack_tgt[i]) begin
                w_ack_data = w_ack_data | portReadData[i*DW +: DW];
            end
        end
    end

`ifdef IP_REG_ROUTER_TIMEOUT_EN
    localparam int c_CW = $clog2(TIMEOUT);

    logic [c_CW-1:0] count_q, count_d;

    // Counting from ISSUE makes the timeout land TIMEOUT cycles after the select pulse.
    always_comb begin
        count_d = '0;
        if (state_q == ISSUE || state_q == WAIT) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clockCore or negedge resetCore) begin
        if (!resetCore) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign w_timeout = (count_q == c_CW'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        read_d   = read_q;
        target_d = target_q;
        acked_d  = acked_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                acked_d = '0;
                err_d   = 1'b0;
                rdata_d = '0;
                if (registerSelect) begin
                    addr_d  = registerAddress;
                    wdata_d = registerWriteData;
                    read_d  = registerRead;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                target_d = read_q ? w_lowest : w_hit;
                if (w_hit == '0) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                acked_d = acked_q | w_ack_tgt;
                err_d   = err_q | w_err_in;
                if (read_q && (w_ack_tgt != '0)) begin
                    rdata_d = w_ack_data;
                end
                if (w_all_acked) begin
                    state_d = RESP;
                end else if (w_timeout) begin
                    acked_d = '0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clockCore or negedge resetCore) begin
        if (!resetCore) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            read_q   <= 1'b0;
            target_q <= '0;
            acked_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            read_q   <= read_d;
            target_q <= target_d;
            acked_q  <= acked_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign registerAck      = (state_q == RESP);
    assign registerError    = registerAck & err_q;
    assign registerReadData = registerAck ? rdata_q : '0;
    assign registerBusy     = (state_q != IDLE);
    assign portSelect       = (state_q == ISSUE) ? target_q : '0;
    assign portRead         = portSelect & {NPORTS{read_q}};
    assign portAddress      = addr_q;
    assign portWriteData    = wdata_q;

endmodule

`default_nettype wire
